dmem_bus_master: RTL and testbench

Initiator side of the core's external data-memory bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n). It sits in the memory stage of the pipeline and turns one load/store request into one bus transaction. It stalls the pipeline until ACKD_n returns, then delivers load data sign- or zero-extended. Misaligned accesses and unacknowledged cycles are terminated locally with an error response.

---
 rtl/dmem_bus_master.sv | 136 +++++++++++++
 tb/tb_dmem_bus_master.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_master.sv
// rtl/dmem_bus_master.sv - memory-stage initiator for the DAD/DDT/MREQ/ACKD_n data bus
module dmem_bus_master #(
  parameter int BIT_WIDTH = 32,
  parameter int MAX_WAIT  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 stall,
  output logic                 resp_valid,
  output logic [BIT_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  output logic [BIT_WIDTH-1:0] DAD,
  inout  wire  [BIT_WIDTH-1:0] DDT,
  input  logic                 ACKD_n
);

  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] C_MAX = CW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t               r_state;
  logic                 r_mreq;
  logic                 r_write;
  logic [1:0]           r_size;
  logic                 r_unsigned;
  logic [BIT_WIDTH-1:0] r_addr;
  logic [BIT_WIDTH-1:0] r_wdata;
  logic [CW-1:0]        r_cnt;
  logic                 r_resp_valid;
  logic                 r_resp_err;
  logic [BIT_WIDTH-1:0] r_resp_rdata;

  logic                 w_misaligned;
  logic                 w_timeout;
  logic [BIT_WIDTH-1:0] w_wlane;
  logic [BIT_WIDTH-1:0] w_rdata_ext;

  assign w_misaligned = ((req_size == 2'b00) && (req_addr[1:0] != 2'b00)) ||
                        ((req_size == 2'b01) && req_addr[0]);
  assign w_timeout    = (MAX_WAIT != 0) && (r_cnt == C_MAX);

  always_comb begin
    w_wlane = '0;
    case (req_size)
      2'b00:   w_wlane = req_wdata;
      2'b01:   w_wlane = {{(BIT_WIDTH-16){1'b0}}, req_wdata[15:0]};
      default: w_wlane = {{(BIT_WIDTH-8){1'b0}}, req_wdata[7:0]};
    endcase
  end

  always_comb begin
    w_rdata_ext = '0;
    case (r_size)
      2'b00:   w_rdata_ext = DDT;
      2'b01:   w_rdata_ext = {{(BIT_WIDTH-16){~r_unsigned & DDT[15]}}, DDT[15:0]};
      default: w_rdata_ext = {{(BIT_WIDTH-8){~r_unsigned & DDT[7]}}, DDT[7:0]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_mreq       <= 1'b0;
      r_write      <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            if (w_misaligned) begin
              r_state      <= DONE;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else begin
              r_state    <= REQ;
              r_mreq     <= 1'b1;
              r_write    <= req_write;
              r_size     <= req_size;
              r_unsigned <= req_unsigned;
              r_addr     <= req_addr;
              r_wdata    <= w_wlane;
              r_cnt      <= '0;
            end
          end
        end
        REQ: begin
          if (!ACKD_n) begin
            r_state      <= DONE;
            r_mreq       <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            if (!r_write) r_resp_rdata <= w_rdata_ext;
          end else if (w_timeout) begin
            r_state      <= DONE;
            r_mreq       <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
          end else if (!(&r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Bus drive follows the async-reset MREQ register, so reset releases DDT at once.
  assign DDT        = (r_mreq && r_write) ? r_wdata : 'z;
  assign MREQ       = r_mreq;
  assign WRITE      = r_write;
  assign SIZE       = r_size;
  assign DAD        = r_addr;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign stall      = req_valid & ~r_resp_valid;

endmodule

// File: tb/tb_dmem_bus_master.sv
// tb/tb_dmem_bus_master.sv - directed bench for dmem_bus_master with MAX_WAIT=4
module tb_dmem_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic [31:0] DAD;
  wire  [31:0] DDT;
  logic        ACKD_n = 1'b1;

  logic        r_mem_en = 1'b0;
  logic [31:0] r_mem_data = '0;

  int n_checks = 0;
  int n_err = 0;

  assign DDT = r_mem_en ? r_mem_data : 'z;

  always #5 clk = ~clk;

  dmem_bus_master #(.BIT_WIDTH(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE), .DAD(DAD), .DDT(DDT), .ACKD_n(ACKD_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] mdata);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    r_mem_en     = !wr;
    r_mem_data   = mdata;
  endtask

  task automatic bus_op(input string tag, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] mdata, input logic [31:0] exp_ddt,
                        input logic [31:0] exp_rd, input int lat);
    present(wr, sz, uns, addr, wdata, mdata);
    ACKD_n = 1'b1;
    #1 chk({tag, ".stall_pre"}, stall, 1);
    @(posedge clk); #1;
    chk({tag, ".mreq"}, MREQ, 1);
    chk({tag, ".write"}, WRITE, wr);
    chk({tag, ".size"}, SIZE, sz);
    chk({tag, ".dad"}, DAD, addr);
    if (wr) chk({tag, ".ddt"}, DDT, exp_ddt);
    for (int i = 1; i < lat; i++) begin
      @(posedge clk); #1;
      chk({tag, ".mreq_wait"}, MREQ, 1);
      chk({tag, ".rv_wait"}, resp_valid, 0);
    end
    ACKD_n = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".mreq_fall"}, MREQ, 0);
    chk({tag, ".resp_valid"}, resp_valid, 1);
    chk({tag, ".resp_err"}, resp_err, 0);
    chk({tag, ".rdata"}, resp_rdata, exp_rd);
    chk({tag, ".stall_resp"}, stall, 0);
    ACKD_n = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    r_mem_en  = 1'b0;
    chk({tag, ".rv_pulse"}, resp_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); @(posedge clk); #1;
    chk("rst.mreq", MREQ, 0);
    chk("rst.write", WRITE, 0);
    chk("rst.size", SIZE, 0);
    chk("rst.dad", DAD, 0);
    chk("rst.resp_valid", resp_valid, 0);
    chk("rst.resp_rdata", resp_rdata, 0);
    chk("rst.resp_err", resp_err, 0);
    chk("rst.stall", stall, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    bus_op("ld_word", 0, 2'b00, 0, 32'h0800_0010, 0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1);
    bus_op("ld_byte_s", 0, 2'b10, 0, 32'h0800_0003, 0, 32'h1234_5680, 0, 32'hFFFF_FF80, 1);
    bus_op("ld_byte_u", 0, 2'b10, 1, 32'h0800_0001, 0, 32'h1234_5680, 0, 32'h0000_0080, 1);
    bus_op("ld_half_s", 0, 2'b01, 0, 32'h0800_0002, 0, 32'hABCD_8001, 0, 32'hFFFF_8001, 1);
    bus_op("st_byte", 1, 2'b10, 0, 32'hF000_0000, 32'h1234_5641, 0, 32'h0000_0041, 32'hFFFF_8001, 1);

    present(0, 2'b00, 0, 32'h0800_0002, 0, 0);
    @(posedge clk); #1;
    chk("mis_w.mreq", MREQ, 0);
    chk("mis_w.resp_valid", resp_valid, 1);
    chk("mis_w.resp_err", resp_err, 1);
    chk("mis_w.stall", stall, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mis_w.rv_pulse", resp_valid, 0);
    chk("mis_w.mreq2", MREQ, 0);

    present(0, 2'b01, 0, 32'h0800_0001, 0, 0);
    @(posedge clk); #1;
    chk("mis_h.mreq", MREQ, 0);
    chk("mis_h.resp_valid", resp_valid, 1);
    chk("mis_h.resp_err", resp_err, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mis_h.rv_pulse", resp_valid, 0);

    // ACKD_n stuck low across two back-to-back loads
    ACKD_n = 1'b0;
    @(posedge clk); #1;
    chk("stale.idle_mreq", MREQ, 0);
    present(0, 2'b00, 0, 32'h0000_0100, 0, 32'h1111_2222);
    @(posedge clk); #1;
    chk("stale.a_mreq", MREQ, 1);
    @(posedge clk); #1;
    chk("stale.a_mreq_fall", MREQ, 0);
    chk("stale.a_rv", resp_valid, 1);
    chk("stale.a_rdata", resp_rdata, 32'h1111_2222);
    @(posedge clk); #1;
    chk("stale.done_no_accept", MREQ, 0);
    chk("stale.a_rv_pulse", resp_valid, 0);
    present(0, 2'b00, 0, 32'h0000_0104, 0, 32'h3333_4444);
    @(posedge clk); #1;
    chk("stale.b_mreq", MREQ, 1);
    chk("stale.b_dad", DAD, 32'h0000_0104);
    @(posedge clk); #1;
    chk("stale.b_mreq_fall", MREQ, 0);
    chk("stale.b_rv", resp_valid, 1);
    chk("stale.b_rdata", resp_rdata, 32'h3333_4444);
    @(posedge clk); #1;
    req_valid = 1'b0;
    r_mem_en  = 1'b0;
    ACKD_n    = 1'b1;
    chk("stale.b_rv_pulse", resp_valid, 0);

    bus_op("lat3", 0, 2'b00, 0, 32'h0800_0020, 0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 3);

    present(0, 2'b00, 0, 32'h0800_0030, 0, 0);
    r_mem_en = 1'b0;
    @(posedge clk); #1;
    chk("tmo.mreq", MREQ, 1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      chk("tmo.mreq_wait", MREQ, 1);
      chk("tmo.rv_wait", resp_valid, 0);
    end
    @(posedge clk); #1;
    chk("tmo.resp_valid", resp_valid, 1);
    chk("tmo.resp_err", resp_err, 1);
    chk("tmo.mreq_fall", MREQ, 0);
    chk("tmo.rdata_hold", resp_rdata, 32'h0BAD_F00D);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("tmo.rv_pulse", resp_valid, 0);

    present(0, 2'b00, 0, 32'h0800_0040, 0, 32'h7777_7777);
    @(posedge clk); #1;
    chk("rstmid.mreq", MREQ, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid.mreq_async", MREQ, 0);
    chk("rstmid.dad_async", DAD, 0);
    chk("rstmid.rv", resp_valid, 0);
    req_valid = 1'b0;
    r_mem_en  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rstmid.no_resp", resp_valid, 0);
    chk("rstmid.idle_mreq", MREQ, 0);
    bus_op("after_rst", 0, 2'b00, 0, 32'h0800_0044, 0, 32'h5A5A_5A5A, 0, 32'h5A5A_5A5A, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
